// File: rtl/alu_sequencer.sv
// alu_sequencer: issue sequencer for a clocked 32-bit MIPS ALU.
// Accepts one request (valid/ready), decodes aluop/funct into the 3-bit
// alucontrol code, drives the ALU operands, waits out the ALU latency,
// captures result/zero and returns them over a valid/ready response channel.
// Ports:
//   i_clk, i_rst_n                   clock, synchronous active-low reset
//   i_req_valid / o_req_ready        request handshake (ready only in IDLE)
//   i_req_aluop, i_req_funct,
//   i_req_shamt, i_req_a, i_req_b    request payload
//   o_alu_a, o_alu_b, o_alucontrol   ALU operands and op code (registered)
//   i_alu_result, i_alu_zero         ALU outputs
//   o_rsp_valid / i_rsp_ready        response handshake
//   o_rsp_result, o_rsp_zero,
//   o_rsp_err                        captured response (err = illegal funct)
module alu_sequencer #(
  parameter int n       = 32,
  parameter int ALU_LAT = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic [1:0]   i_req_aluop,
  input  logic [5:0]   i_req_funct,
  input  logic [4:0]   i_req_shamt,
  input  logic [n-1:0] i_req_a,
  input  logic [n-1:0] i_req_b,
  output logic [n-1:0] o_alu_a,
  output logic [n-1:0] o_alu_b,
  output logic [2:0]   o_alucontrol,
  input  logic [n-1:0] i_alu_result,
  input  logic         i_alu_zero,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [n-1:0] o_rsp_result,
  output logic         o_rsp_zero,
  output logic         o_rsp_err
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_req_ready;
  logic           r_illegal;
  logic [n-1:0]   r_alu_a, r_alu_b;
  logic [2:0]     r_code;
  logic           r_rsp_valid, r_rsp_zero, r_rsp_err;
  logic [n-1:0]   r_rsp_result;

  logic [2:0]     w_code;
  logic           w_illegal;
  logic           w_shift;
  logic [n-1:0]   w_op_a;
  logic           w_accept;

  // aluop/funct decode
  always_comb begin
    w_code    = 3'b000;
    w_illegal = 1'b0;
    w_shift   = 1'b0;
    case (i_req_aluop)
      2'b00: w_code = 3'b000;
      2'b01: w_code = 3'b001;
      2'b11: w_code = 3'b011;
      default: begin
        case (i_req_funct)
          6'b100000: w_code = 3'b000;
          6'b100010: w_code = 3'b001;
          6'b100100: w_code = 3'b010;
          6'b100101: w_code = 3'b011;
          6'b100110: w_code = 3'b100;
          6'b100111: w_code = 3'b101;
          6'b000000: begin w_code = 3'b110; w_shift = 1'b1; end
          6'b000011: begin w_code = 3'b111; w_shift = 1'b1; end
          default:   w_illegal = 1'b1;
        endcase
      end
    endcase
  end

  // Shifts take the amount on operand a; the value to shift rides on b.
  assign w_op_a   = w_shift ? {{(n-5){1'b0}}, i_req_shamt} : i_req_a;
  assign w_accept = i_req_valid && r_req_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b0;
      r_illegal    <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_code       <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_illegal   <= w_illegal;
            r_state     <= ISSUE;
            // An illegal request leaves the ALU operands untouched.
            if (!w_illegal) begin
              r_alu_a <= w_op_a;
              r_alu_b <= i_req_b;
              r_code  <= w_code;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ISSUE: begin
          r_cnt <= '0;
          // Illegal requests report from the ISSUE slot so the error
          // response appears one edge after acceptance.
          if (r_illegal) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_err    <= 1'b1;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_state      <= RESP;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == CW'(ALU_LAT - 1)) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_err    <= 1'b0;
            r_rsp_result <= i_alu_result;
            r_rsp_zero   <= i_alu_zero;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alucontrol = r_code;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_zero   = r_rsp_zero;
  assign o_rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural registered ALU, scoreboard queue of
// expected responses filled at request time and drained at response time.
module tb_alu_sequencer;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   aluop = '0;
  logic [5:0]   funct = '0;
  logic [4:0]   shamt = '0;
  logic [N-1:0] a = '0, b = '0;
  logic [N-1:0] alu_a, alu_b;
  logic [2:0]   alucontrol;
  logic [N-1:0] alu_result = '0;
  logic         alu_zero;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [N-1:0] rsp_result;
  logic         rsp_zero, rsp_err;

  alu_sequencer #(.n(N), .ALU_LAT(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_aluop(aluop), .i_req_funct(funct), .i_req_shamt(shamt),
    .i_req_a(a), .i_req_b(b),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alucontrol(alucontrol),
    .i_alu_result(alu_result), .i_alu_zero(alu_zero),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_zero(rsp_zero), .o_rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Clocked ALU, one register stage.
  always @(posedge clk) begin
    case (alucontrol)
      3'b000: alu_result <= alu_a + alu_b;
      3'b001: alu_result <= alu_a - alu_b;
      3'b010: alu_result <= alu_a & alu_b;
      3'b011: alu_result <= alu_a | alu_b;
      3'b100: alu_result <= alu_a ^ alu_b;
      3'b101: alu_result <= ~(alu_a | alu_b);
      3'b110: alu_result <= alu_b << alu_a[4:0];
      default: alu_result <= N'($signed(alu_b) >>> alu_a[4:0]);
    endcase
  end
  assign alu_zero = (alu_result == '0);

  typedef struct packed {
    logic         err;
    logic         zero;
    logic [N-1:0] res;
    logic [2:0]   code;
    logic [N-1:0] aa;
    logic [N-1:0] bb;
  } exp_t;

  exp_t sbq[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [4:0] sh, input logic [N-1:0] x,
                                 input logic [N-1:0] y);
    exp_t e;
    e = '0;
    e.aa = x;
    e.bb = y;
    case (op)
      2'b00: begin e.code = 3'd0; e.res = x + y; end
      2'b01: begin e.code = 3'd1; e.res = x - y; end
      2'b11: begin e.code = 3'd3; e.res = x | y; end
      default: begin
        case (fn)
          6'h20: begin e.code = 3'd0; e.res = x + y; end
          6'h22: begin e.code = 3'd1; e.res = x - y; end
          6'h24: begin e.code = 3'd2; e.res = x & y; end
          6'h25: begin e.code = 3'd3; e.res = x | y; end
          6'h26: begin e.code = 3'd4; e.res = x ^ y; end
          6'h27: begin e.code = 3'd5; e.res = ~(x | y); end
          6'h00: begin e.code = 3'd6; e.aa = {27'b0, sh}; e.res = y << sh; end
          6'h03: begin e.code = 3'd7; e.aa = {27'b0, sh}; e.res = N'($signed(y) >>> sh); end
          default: e.err = 1'b1;
        endcase
      end
    endcase
    if (!e.err) e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [N-1:0] x, input logic [N-1:0] y, input int stall);
    exp_t e, got_e;
    logic [2:0]   prev_code;
    logic [N-1:0] prev_a;
    int t, k;
    e = model(op, fn, sh, x, y);
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin chk("req_ready_timeout", 0, 1); return; end
    prev_code = alucontrol;
    prev_a    = alu_a;
    aluop = op; funct = fn; shamt = sh; a = x; b = y;
    req_valid = 1'b1;
    sbq.push_back(e);
    @(negedge clk);            // acceptance edge E0 has passed
    req_valid = 1'b0;
    a = $urandom; b = $urandom; // don't-care after acceptance
    chk("req_ready_low", req_ready, 0);
    if (!e.err) begin
      chk("alucontrol", alucontrol, e.code);
      chk("alu_a", alu_a, e.aa);
      chk("alu_b", alu_b, e.bb);
    end else begin
      chk("alucontrol_hold", alucontrol, prev_code);
      chk("alu_a_hold", alu_a, prev_a);
    end
    k = 0;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin
      chk("rsp_timeout", 0, 1);
      void'(sbq.pop_front());
      return;
    end
    chk("latency", k, e.err ? 1 : 2);
    if (sbq.size() == 0) begin chk("sb_empty", 0, 1); return; end
    got_e = sbq.pop_front();
    chk("rsp_result", rsp_result, got_e.res);
    chk("rsp_zero", rsp_zero, got_e.zero);
    chk("rsp_err", rsp_err, got_e.err);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_result", rsp_result, got_e.res);
      chk("hold_err", rsp_err, got_e.err);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("idle_req_ready", req_ready, 1);
  endtask

  logic [5:0] fn_tbl[10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h00, 6'h03, 6'h2a, 6'h08};

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alucontrol", alucontrol, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);

    do_op(2'b10, 6'h20, 5'd0, 32'd5, 32'd7, 0);
    do_op(2'b01, 6'h00, 5'd0, 32'd9, 32'd9, 0);
    do_op(2'b10, 6'h00, 5'd4, 32'd0, 32'd1, 0);
    do_op(2'b10, 6'h03, 5'd31, 32'd0, 32'h8000_0000, 0);
    do_op(2'b10, 6'h2a, 5'd0, 32'd3, 32'd4, 0);
    do_op(2'b10, 6'h24, 5'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
    do_op(2'b10, 6'h26, 5'd0, 32'hAAAA_5555, 32'hFFFF_0000, 1);
    do_op(2'b10, 6'h27, 5'd0, 32'h0000_0000, 32'h0000_0000, 0);
    do_op(2'b11, 6'h3f, 5'd0, 32'h1200_0000, 32'h0000_0034, 0);
    do_op(2'b00, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'd1, 5);
    do_op(2'b10, 6'h08, 5'd0, 32'd1, 32'd2, 3);
    for (int i = 0; i < 10; i++)
      do_op(2'($urandom_range(0, 3)), fn_tbl[$urandom_range(0, 9)], 5'($urandom),
            $urandom, $urandom, $urandom_range(0, 2));

    // Reset while in WAIT drops the operation.
    aluop = 2'b00; a = 32'd100; b = 32'd200; req_valid = 1'b1;
    @(negedge clk);            // E0: accepted
    req_valid = 1'b0;
    @(negedge clk);            // E1: now in WAIT
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_alu_b", alu_b, 0);
    chk("midrst_alucontrol", alucontrol, 0);
    @(negedge clk);
    chk("midrst_rsp_valid2", rsp_valid, 0);
    chk("midrst_idle_ready", req_ready, 1);
    do_op(2'b00, 6'h00, 5'd0, 32'd1, 32'd1, 0);

    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
